// File: rtl/spi2adc.sv
// SPI initiator for the MCP3002 ADC: one single-ended 10-bit conversion per start pulse.
// Outputs are registered from the current state, so every output lags the state register by one sysclk.
module spi2adc #(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       start,
  input  logic       channel,
  input  logic       adc_sdi,
  output logic       adc_sdo,
  output logic       adc_cs,
  output logic       adc_sck,
  output logic [9:0] data_out,
  output logic       data_valid,
  output logic       busy
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic          hi_q, hi_d;
  logic          ch_q, ch_d;
  logic [9:0]    shreg_q, shreg_d;
  logic          sdo_q, sdo_d;
  logic          cs_q, cs_d;
  logic          sck_q, sck_d;
  logic [9:0]    data_q, data_d;
  logic          dv_q, dv_d;
  logic          busy_q, busy_d;

  logic          tc;
  logic          first;
  logic [15:0]   cmd;

  assign tc    = (cnt_q == '0);
  assign first = (cnt_q == CNT_TOP);
  // Bit for SCK period n sits at index 16-n: lead zero, start, SGL, ODD, MSBF, then zeros.
  assign cmd   = {3'b011, ch_q, 1'b1, 11'd0};

  always_comb begin
    state_d = state_q;
    cnt_d   = tc ? CNT_TOP : cnt_q - 1'b1;
    bit_d   = bit_q;
    hi_d    = hi_q;
    ch_d    = ch_q;
    shreg_d = shreg_q;
    sdo_d   = sdo_q;
    data_d  = data_q;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = CNT_TOP;
        bit_d = 4'd0;
        hi_d  = 1'b0;
        if (start) begin
          state_d = S_SETUP;
          ch_d    = channel;
        end
      end
      S_SETUP: begin
        if (tc) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (tc) begin
          hi_d = ~hi_q;
          if (hi_q) begin
            bit_d = bit_q + 4'd1;
            if (bit_q == 4'd15) state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (tc) state_d = S_GAP;
      end
      S_GAP: begin
        if (tc) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    cs_d   = !((state_q == S_SETUP) || (state_q == S_SHIFT) || (state_q == S_HOLD));
    sck_d  = (state_q == S_SHIFT) && hi_q;
    busy_d = (state_q != S_IDLE);
    dv_d   = (state_q == S_GAP) && first;

    if ((state_q == S_SHIFT) && !hi_q && first)
      sdo_d = cmd[4'd15 - bit_q];

    // Sampled on the same edge that raises SCK; rise 6 carries the null bit and is skipped.
    if ((state_q == S_SHIFT) && hi_q && first && (bit_q >= 4'd6))
      shreg_d = {shreg_q[8:0], adc_sdi};

    if (dv_d)
      data_d = shreg_q;
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_TOP;
      bit_q   <= 4'd0;
      hi_q    <= 1'b0;
      ch_q    <= 1'b0;
      shreg_q <= 10'd0;
      sdo_q   <= 1'b0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
      data_q  <= 10'd0;
      dv_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      hi_q    <= hi_d;
      ch_q    <= ch_d;
      shreg_q <= shreg_d;
      sdo_q   <= sdo_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      busy_q  <= busy_d;
    end
  end

  assign adc_sdo    = sdo_q;
  assign adc_cs     = cs_q;
  assign adc_sck    = sck_q;
  assign data_out   = data_q;
  assign data_valid = dv_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_spi2adc.sv
// Directed bench for spi2adc: instance A at CLK_DIV=25, instance B at CLK_DIV=2, each against an MCP3002 model.
module tb_spi2adc;

  logic sysclk = 1'b0;
  always #10 sysclk = ~sysclk;

  logic       rst_a = 1'b1, start_a = 1'b0, ch_a = 1'b0, sdi_a = 1'b0;
  logic       sdo_a, cs_a, sck_a, dv_a, busy_a;
  logic [9:0] dout_a;

  logic       rst_b = 1'b1, start_b = 1'b0, ch_b = 1'b0, sdi_b = 1'b0;
  logic       sdo_b, cs_b, sck_b, dv_b, busy_b;
  logic [9:0] dout_b;

  spi2adc #(.CLK_DIV(25)) u_a (
    .sysclk(sysclk), .reset(rst_a), .start(start_a), .channel(ch_a), .adc_sdi(sdi_a),
    .adc_sdo(sdo_a), .adc_cs(cs_a), .adc_sck(sck_a), .data_out(dout_a),
    .data_valid(dv_a), .busy(busy_a)
  );

  spi2adc #(.CLK_DIV(2)) u_b (
    .sysclk(sysclk), .reset(rst_b), .start(start_b), .channel(ch_b), .adc_sdi(sdi_b),
    .adc_sdo(sdo_b), .adc_cs(cs_b), .adc_sck(sck_b), .data_out(dout_b),
    .data_valid(dv_b), .busy(busy_b)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // MCP3002 models: Dout changes on falling SCK; null bit after fall 5, B9..B0 after falls 6..15.
  logic [9:0] smp_a = 10'd0, smp_b = 10'd0;
  int fall_a = 0, fall_b = 0;

  always @(negedge sck_a or posedge cs_a) begin
    if (cs_a) begin
      fall_a = 0;
      sdi_a  = 1'b0;
    end else begin
      fall_a++;
      if (fall_a >= 6 && fall_a <= 15) sdi_a = smp_a[4'(15 - fall_a)];
      else sdi_a = 1'b0;
    end
  end

  always @(negedge sck_b or posedge cs_b) begin
    if (cs_b) begin
      fall_b = 0;
      sdi_b  = 1'b0;
    end else begin
      fall_b++;
      if (fall_b >= 6 && fall_b <= 15) sdi_b = smp_b[4'(15 - fall_b)];
      else sdi_b = 1'b0;
    end
  end

  int cyc = 0;
  always @(posedge sysclk) cyc++;

  int          rise_a = 0;
  logic [15:0] cmdw_a = 16'd0;
  int          dvn_a = 0;
  always @(posedge sck_a) begin
    rise_a++;
    cmdw_a = {cmdw_a[14:0], sdo_a};
  end
  always @(negedge sysclk) if (dv_a) dvn_a++;

  int rise_b = 0;
  int rt_b0 = 0, rt_b1 = 0;
  always @(posedge sck_b) begin
    if (rise_b == 0) rt_b0 = cyc;
    if (rise_b == 1) rt_b1 = cyc;
    rise_b++;
  end

  task automatic go_a(input logic ch);
    @(negedge sysclk);
    ch_a = ch;
    start_a = 1'b1;
    @(posedge sysclk);
    #1;
    start_a = 1'b0;
    ch_a = ~ch;
  endtask

  task automatic go_b(input logic ch);
    @(negedge sysclk);
    ch_b = ch;
    start_b = 1'b1;
    @(posedge sysclk);
    #1;
    start_b = 1'b0;
    ch_b = ~ch;
  endtask

  task automatic wait_dv_a(input int n0, output int n);
    n = n0;
    do begin
      @(posedge sysclk);
      #1;
      n++;
    end while (!dv_a && n < 3000);
  endtask

  task automatic wait_dv_b(input int n0, output int n);
    n = n0;
    do begin
      @(posedge sysclk);
      #1;
      n++;
    end while (!dv_b && n < 3000);
  endtask

  task automatic idle_a(input string tag);
    int k;
    k = 0;
    while (busy_a && k < 3000) begin
      @(posedge sysclk);
      #1;
      k++;
    end
    chk(tag, busy_a, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t0, gap;

    // Reset values
    repeat (3) @(posedge sysclk);
    #1;
    chk("rst cs", cs_a, 1);
    chk("rst sck", sck_a, 0);
    chk("rst sdo", sdo_a, 0);
    chk("rst dout", dout_a, 0);
    chk("rst dv", dv_a, 0);
    chk("rst busy", busy_a, 0);
    @(negedge sysclk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (2) @(posedge sysclk);
    #1;

    // 1: channel 0, sample 0x2AA
    smp_a = 10'h2AA; rise_a = 0; cmdw_a = 16'd0; dvn_a = 0;
    go_a(1'b0);
    @(posedge sysclk);
    #1;
    chk("t1 cs at T0+1", cs_a, 0);
    chk("t1 busy at T0+1", busy_a, 1);
    wait_dv_a(1, n);
    chk("t1 dv time", n, 1 + 34 * 25);
    chk("t1 dout", dout_a, 10'h2AA);
    chk("t1 cs high at dv", cs_a, 1);
    @(posedge sysclk);
    #1;
    chk("t1 dv one cycle", dv_a, 0);
    idle_a("t1 idle");
    chk("t1 rises", rise_a, 16);
    chk("t1 cmd word", cmdw_a, 16'h6800);
    chk("t1 dv count", dvn_a, 1);

    // 2: channel 1, 0x3FF then 0x000
    smp_a = 10'h3FF; rise_a = 0; cmdw_a = 16'd0; dvn_a = 0;
    go_a(1'b1);
    wait_dv_a(0, n);
    chk("t2a dv time", n, 1 + 34 * 25);
    chk("t2a dout", dout_a, 10'h3FF);
    idle_a("t2a idle");
    chk("t2a cmd word", cmdw_a, 16'h7800);
    smp_a = 10'h000; cmdw_a = 16'd0;
    go_a(1'b1);
    wait_dv_a(0, n);
    chk("t2b dout", dout_a, 10'h000);
    idle_a("t2b idle");
    chk("t2b cmd word", cmdw_a, 16'h7800);
    chk("t2 dv count", dvn_a, 2);

    // 3: starts while busy are dropped; earliest legal start accepted
    smp_a = 10'h1C3; dvn_a = 0;
    go_a(1'b0);
    for (int k = 1; k <= 35 * 25 + 2; k++) begin
      start_a = (k == 5 || k == 35 * 25 || k == 35 * 25 + 1);
      @(posedge sysclk);
      #1;
      if (k == 1 + 34 * 25) begin
        chk("t3 dv time", dv_a, 1);
        chk("t3 dout", dout_a, 10'h1C3);
      end
      if (k == 35 * 25) chk("t3 busy before fall", busy_a, 1);
      if (k == 35 * 25 + 1) begin
        chk("t3 busy fall", busy_a, 0);
        chk("t3 late start ignored", cs_a, 1);
      end
      if (k == 35 * 25 + 2) begin
        chk("t3 accepted cs", cs_a, 0);
        chk("t3 accepted busy", busy_a, 1);
      end
    end
    start_a = 1'b0;
    wait_dv_a(1, n);
    chk("t3 second dv time", n, 1 + 34 * 25);
    idle_a("t3 idle");
    repeat (100) @(posedge sysclk);
    #1;
    chk("t3 no queued frame", busy_a, 0);
    chk("t3 dv count", dvn_a, 2);

    // 4: reset one cycle after SCK rise 9
    smp_a = 10'h2AA; rise_a = 0; dvn_a = 0;
    go_a(1'b0);
    n = 0;
    while (rise_a < 9 && n < 3000) begin
      @(posedge sysclk);
      #1;
      n++;
    end
    chk("t4 reached rise 9", rise_a, 9);
    rst_a = 1'b1;
    @(posedge sysclk);
    #1;
    rst_a = 1'b0;
    chk("t4 cs", cs_a, 1);
    chk("t4 sck", sck_a, 0);
    chk("t4 dout", dout_a, 0);
    chk("t4 busy", busy_a, 0);
    repeat (1000) @(posedge sysclk);
    #1;
    chk("t4 no dv", dvn_a, 0);
    chk("t4 no more rises", rise_a, 9);
    smp_a = 10'h0F0; rise_a = 0;
    go_a(1'b1);
    wait_dv_a(0, n);
    chk("t4 recover dv time", n, 1 + 34 * 25);
    chk("t4 recover dout", dout_a, 10'h0F0);
    idle_a("t4 idle");
    chk("t4 recover rises", rise_a, 16);

    // 5: CLK_DIV = 2, back-to-back frames
    smp_b = 10'h155; rise_b = 0;
    go_b(1'b0);
    t0 = cyc;
    wait_dv_b(0, n);
    chk("t5 dv time", n, 69);
    chk("t5 dout", dout_b, 10'h155);
    chk("t5 first rise", rt_b0 - t0, 5);
    chk("t5 sck period", rt_b1 - rt_b0, 4);
    gap = cs_b ? 1 : 0;
    @(posedge sysclk);
    #1;
    if (cs_b && gap > 0) gap++;
    smp_b = 10'h2A5;
    start_b = 1'b1;
    @(posedge sysclk);
    #1;
    start_b = 1'b0;
    if (cs_b && gap > 1) gap++;
    @(posedge sysclk);
    #1;
    if (cs_b && gap > 2) gap++;
    chk("t5 cs gap", gap, 3);
    chk("t5 cs low again", cs_b, 0);
    wait_dv_b(1, n);
    chk("t5 second dv time", n, 69);
    chk("t5 second dout", dout_b, 10'h2A5);
    chk("t5 rises", rise_b, 32);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
